packet_arb_wrr: RTL

Weighted round-robin packet arbiter for `if_axi_stream` traffic. It merges NUM_IN packet streams onto one output and never interleaves beats of different packets. Per-input weights, set at run time, give the number of consecutive packets an input may send per turn. It sits ahead of shared packet datapaths, such as the tree arbiter's root or a shared multiplier core, where plain round-robin starves bulk requesters.

---
 rtl/packet_arb_wrr_if.sv | 26 ++
 rtl/packet_arb_wrr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_arb_wrr_if.sv
// Valid/ready packet stream bundle used on both sides of packet_arb_wrr.
// sink: consumer view (drives rdy); source: producer view (drives the rest).
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
);
    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [DAT_BYTS*8-1:0] dat;
    logic [MOD_BITS-1:0]   mod;
    logic [CTL_BITS-1:0]   ctl;

    modport sink (
        input  val, sop, eop, err, dat, mod, ctl,
        output rdy
    );

    modport source (
        output val, sop, eop, err, dat, mod, ctl,
        input  rdy
    );
endinterface

// File: rtl/packet_arb_wrr.sv
// Weighted round-robin packet arbiter: whole packets, weight = packets/turn.
// Optional per-input eop counters on o_pkt_cnt when PACKET_ARB_WRR_STATS_EN.
module packet_arb_wrr #(
    parameter int DAT_BYTS     = 8,
    parameter int DAT_BITS     = DAT_BYTS * 8,
    parameter int CTL_BITS     = 8,
    parameter int NUM_IN       = 2,
    parameter int W_BITS       = 4,
    parameter int OVERRIDE_CTL = 1,
    parameter int OVR_WRT_BIT  = CTL_BITS - $clog2(NUM_IN)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_IN*W_BITS-1:0] i_weight,
    if_axi_stream.sink               i_axi [NUM_IN],
    if_axi_stream.source             o_axi
`ifdef PACKET_ARB_WRR_STATS_EN
    ,
    output logic [NUM_IN*32-1:0]     o_pkt_cnt
`endif
);

    localparam int GW       = $clog2(NUM_IN);
    localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;
    localparam logic [W_BITS-1:0] W_ONE = W_BITS'(1);
    localparam logic [GW-1:0]     G_LAST = GW'(NUM_IN - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       gnt_q, gnt_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [W_BITS-1:0]   credit_q, credit_d;

    logic                o_val_q, o_val_d;
    logic                o_sop_q, o_sop_d;
    logic                o_eop_q, o_eop_d;
    logic                o_err_q, o_err_d;
    logic [DAT_BITS-1:0] o_dat_q, o_dat_d;
    logic [MOD_BITS-1:0] o_mod_q, o_mod_d;
    logic [CTL_BITS-1:0] o_ctl_q, o_ctl_d;

    logic [NUM_IN-1:0]   in_val;
    logic [NUM_IN-1:0]   in_sop;
    logic [NUM_IN-1:0]   in_eop;
    logic [NUM_IN-1:0]   in_err;
    logic [DAT_BITS-1:0] in_dat [NUM_IN];
    logic [MOD_BITS-1:0] in_mod [NUM_IN];
    logic [CTL_BITS-1:0] in_ctl [NUM_IN];
    logic [NUM_IN-1:0]   rdy_vec;

    logic                hit;
    logic [GW-1:0]       hit_idx;
    logic [W_BITS-1:0]   hit_w;
    logic [GW-1:0]       hit_nxt;
    logic                out_rdy;
    logic                accept;
    logic                sel_val;
    logic                sel_eop;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        assign in_val[k]    = i_axi[k].val;
        assign in_sop[k]    = i_axi[k].sop;
        assign in_eop[k]    = i_axi[k].eop;
        assign in_err[k]    = i_axi[k].err;
        assign in_dat[k]    = i_axi[k].dat;
        assign in_mod[k]    = i_axi[k].mod;
        assign in_ctl[k]    = i_axi[k].ctl;
        assign i_axi[k].rdy = rdy_vec[k];
    end

    // Rotating search for the first valid input with a nonzero weight
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            automatic int k = int'(ptr_q) + i;
            if (k >= NUM_IN) k = k - NUM_IN;
            if (!hit && in_val[k] && i_weight[k*W_BITS +: W_BITS] != '0) begin
                hit     = 1'b1;
                hit_idx = GW'(k);
            end
        end
        hit_w   = i_weight[int'(hit_idx)*W_BITS +: W_BITS];
        hit_nxt = (hit_idx == G_LAST) ? '0 : hit_idx + GW'(1);
    end

    // Granted-input handshake; only the granted input ever sees rdy
    always_comb begin
        out_rdy = !o_val_q || o_axi.rdy;
        sel_val = in_val[gnt_q];
        sel_eop = in_eop[gnt_q];
        accept  = (state_q == XFER) && sel_val && out_rdy;
        rdy_vec = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            rdy_vec[k] = (state_q == XFER) && (gnt_q == GW'(k)) && out_rdy;
        end
    end

    // Turn control: grant in IDLE, hold until eop, burn credit per packet
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d  = XFER;
                    gnt_d    = hit_idx;
                    credit_d = hit_w - W_ONE;
                    ptr_d    = hit_nxt;
                end
            end
            XFER: begin
                if (accept && sel_eop) begin
                    if (credit_q != '0) credit_d = credit_q - W_ONE;
                    else                state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load on accept, drop val once the sink takes it
    always_comb begin
        o_val_d = o_val_q;
        o_sop_d = o_sop_q;
        o_eop_d = o_eop_q;
        o_err_d = o_err_q;
        o_dat_d = o_dat_q;
        o_mod_d = o_mod_q;
        o_ctl_d = o_ctl_q;
        if (accept) begin
            o_val_d = 1'b1;
            o_sop_d = in_sop[gnt_q];
            o_eop_d = in_eop[gnt_q];
            o_err_d = in_err[gnt_q];
            o_dat_d = in_dat[gnt_q];
            o_mod_d = in_mod[gnt_q];
            o_ctl_d = in_ctl[gnt_q];
            if (OVERRIDE_CTL == 1) o_ctl_d[OVR_WRT_BIT +: GW] = gnt_q;
        end else if (o_axi.rdy) begin
            o_val_d = 1'b0;
        end
    end

`ifdef PACKET_ARB_WRR_STATS_EN
    logic [NUM_IN-1:0][31:0] cnt_q, cnt_d;

    // Count eop beats per source as they enter the output register
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_IN; k++) begin
            if (accept && sel_eop && gnt_q == GW'(k)) cnt_d[k] = cnt_q[k] + 32'd1;
        end
    end

    assign o_pkt_cnt = cnt_q;
`endif

    // State and output flops with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            o_val_q  <= 1'b0;
            o_sop_q  <= 1'b0;
            o_eop_q  <= 1'b0;
            o_err_q  <= 1'b0;
            o_dat_q  <= '0;
            o_mod_q  <= '0;
            o_ctl_q  <= '0;
`ifdef PACKET_ARB_WRR_STATS_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            o_val_q  <= o_val_d;
            o_sop_q  <= o_sop_d;
            o_eop_q  <= o_eop_d;
            o_err_q  <= o_err_d;
            o_dat_q  <= o_dat_d;
            o_mod_q  <= o_mod_d;
            o_ctl_q  <= o_ctl_d;
`ifdef PACKET_ARB_WRR_STATS_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign o_axi.val = o_val_q;
    assign o_axi.sop = o_sop_q;
    assign o_axi.eop = o_eop_q;
    assign o_axi.err = o_err_q;
    assign o_axi.dat = o_dat_q;
    assign o_axi.mod = o_mod_q;
    assign o_axi.ctl = o_ctl_q;

endmodule
